gate_delay_scheduler: RTL and testbench

- Shares one gate/delay pulse generator among N_REQ independent trigger sources.
- Each source has its own delay/width setting. The block latches trigger edges per source and grants the generator round-robin.
- On grant it presents that source's delay/width to the generator, fires a one-cycle trigger, and holds the selection until the generator's busy drops.
- Sits between front-panel/experiment trigger inputs and the shared pulse-generator instance.

---
 rtl/gate_delay_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_gate_delay_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_delay_scheduler.sv
// gate_delay_scheduler: shares one gate/delay pulse generator among
// N_REQ edge-triggered requesters with round-robin arbitration.
module gate_delay_scheduler #(
   parameter int N_REQ       = 4,
   parameter int CNT_W       = 32,
   parameter int ACK_TIMEOUT = 16,
   parameter int DROP_W      = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [N_REQ-1:0]           i_req,
   input  logic [N_REQ-1:0]           i_enable,
   input  logic [N_REQ*CNT_W-1:0]     i_delay,
   input  logic [N_REQ*CNT_W-1:0]     i_width,
   input  logic                       i_gen_busy,
   output logic                       o_gen_trigger,
   output logic [CNT_W-1:0]           o_gen_delay,
   output logic [CNT_W-1:0]           o_gen_width,
   output logic [$clog2(N_REQ)-1:0]   o_grant_id,
   output logic                       o_active,
   output logic [N_REQ-1:0]           o_pending,
   output logic [DROP_W-1:0]          o_drop_cnt,
   output logic                       o_timeout
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ID_W:0]    N_L      = (ID_W+1)'(N_REQ);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      WAIT_ACK,
      RUN
   } state_t;

   state_t state, state_nxt;

   logic [N_REQ-1:0] sync1, sync2, sync3, edge_r;
   logic [N_REQ-1:0] edge_v, pending, pending_nxt;
   logic [N_REQ-1:0] clr, drops;

   logic [DROP_W-1:0] drop_cnt, drop_nxt;

   logic [ID_W-1:0] ptr, ptr_nxt, sel, grant_id;
   logic [ID_W:0]   idx;
   logic            found;
   logic            load;

   logic [CNT_W-1:0] dly_a [N_REQ];
   logic [CNT_W-1:0] wid_a [N_REQ];
   logic [CNT_W-1:0] gen_delay, gen_width;

   logic trig, trig_nxt;
   logic active, active_nxt;
   logic timeout, timeout_nxt;

   logic [ACK_W-1:0] ack_cnt, ack_nxt;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign dly_a[g] = i_delay[g*CNT_W +: CNT_W];
      assign wid_a[g] = i_width[g*CNT_W +: CNT_W];
   end

   // two-flop synchronizer followed by a registered rising-edge detect
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         sync3  <= '0;
         edge_r <= '0;
      end else begin
         sync1  <= i_req;
         sync2  <= sync1;
         sync3  <= sync2;
         edge_r <= sync2 & ~sync3;
      end
   end

   // a new edge wins over a same-cycle grant clear; disabling flushes
   assign edge_v      = edge_r & i_enable;
   assign drops       = edge_v & pending & ~clr;
   assign pending_nxt = ((pending & ~clr) | edge_v) & i_enable;

   // saturating count of edges lost on an already-pending requester
   always_comb begin
      drop_nxt = drop_cnt;
      for (int k = 0; k < N_REQ; k++) begin
         if (drops[k] && (drop_nxt != '1)) begin
            drop_nxt = drop_nxt + DROP_W'(1);
         end
      end
   end

   // first pending requester at or above the pointer, wrapping
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = {1'b0, ptr} + (ID_W+1)'(i);
         if (idx >= N_L) begin
            idx = idx - N_L;
         end
         if (!found && pending[idx[ID_W-1:0]]) begin
            found = 1'b1;
            sel   = idx[ID_W-1:0];
         end
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state, grant load and registered-output updates
   always_comb begin
      state_nxt   = state;
      clr         = '0;
      load        = 1'b0;
      ptr_nxt     = ptr;
      trig_nxt    = 1'b0;
      active_nxt  = active;
      timeout_nxt = timeout;
      ack_nxt     = ack_cnt;
      unique case (state)
         IDLE: begin
            if (found) begin
               clr[sel] = 1'b1;
               ptr_nxt  = (sel == ID_LAST) ? '0 : sel + ID_W'(1);
               if (wid_a[sel] != '0) begin
                  load      = 1'b1;
                  state_nxt = ARM;
               end
            end
         end
         ARM: begin
            trig_nxt   = 1'b1;
            active_nxt = 1'b1;
            ack_nxt    = '0;
            state_nxt  = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (i_gen_busy) begin
               state_nxt = RUN;
            end else if (ack_cnt == ACK_LAST) begin
               timeout_nxt = 1'b1;
               active_nxt  = 1'b0;
               state_nxt   = IDLE;
            end else begin
               ack_nxt = ack_cnt + ACK_W'(1);
            end
         end
         RUN: begin
            if (!i_gen_busy) begin
               active_nxt = 1'b0;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // datapath registers: pending, drop count, grant, outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending   <= '0;
         drop_cnt  <= '0;
         ptr       <= '0;
         grant_id  <= '0;
         gen_delay <= '0;
         gen_width <= '0;
         trig      <= 1'b0;
         active    <= 1'b0;
         timeout   <= 1'b0;
         ack_cnt   <= '0;
      end else begin
         pending  <= pending_nxt;
         drop_cnt <= drop_nxt;
         ptr      <= ptr_nxt;
         trig     <= trig_nxt;
         active   <= active_nxt;
         timeout  <= timeout_nxt;
         ack_cnt  <= ack_nxt;
         if (load) begin
            grant_id  <= sel;
            gen_delay <= dly_a[sel];
            gen_width <= wid_a[sel];
         end
      end
   end

   assign o_gen_trigger = trig;
   assign o_gen_delay   = gen_delay;
   assign o_gen_width   = gen_width;
   assign o_grant_id    = grant_id;
   assign o_active      = active;
   assign o_pending     = pending;
   assign o_drop_cnt    = drop_cnt;
   assign o_timeout     = timeout;

endmodule

// File: tb/tb_gate_delay_scheduler.sv
// tb_gate_delay_scheduler: directed checks of arbitration, latency,
// drops, timeout, zero width and async reset for gate_delay_scheduler.
module tb_gate_delay_scheduler;

   localparam int N     = 4;
   localparam int CW    = 32;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N-1:0]  enable;
   logic [CW-1:0] dly [N];
   logic [CW-1:0] wid [N];
   logic          busy;
   logic          gen_trigger;
   logic [CW-1:0] gen_delay;
   logic [CW-1:0] gen_width;
   logic [1:0]    grant_id;
   logic          active;
   logic [N-1:0]  pending;
   logic [DW-1:0] drop_cnt;
   logic          timeout;

   int n_cmp = 0;
   int n_err = 0;

   logic gen_en;
   int   gen_len;
   int   phase;

   always #5 clk = ~clk;

   gate_delay_scheduler #(
      .N_REQ(N),
      .CNT_W(CW),
      .ACK_TIMEOUT(16),
      .DROP_W(DW)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_req(req),
      .i_enable(enable),
      .i_delay({dly[3], dly[2], dly[1], dly[0]}),
      .i_width({wid[3], wid[2], wid[1], wid[0]}),
      .i_gen_busy(busy),
      .o_gen_trigger(gen_trigger),
      .o_gen_delay(gen_delay),
      .o_gen_width(gen_width),
      .o_grant_id(grant_id),
      .o_active(active),
      .o_pending(pending),
      .o_drop_cnt(drop_cnt),
      .o_timeout(timeout)
   );

   // generator model: busy from 2 cycles after trigger for gen_len cycles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 0;
      end else if (phase == 0) begin
         if (gen_trigger && gen_en) phase <= 1;
      end else if (phase >= gen_len + 1) begin
         phase <= 0;
      end else begin
         phase <= phase + 1;
      end
   end

   assign busy = gen_en && (phase >= 2) && (phase <= gen_len + 1);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_trig(input int budget, output logic hit);
      hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (gen_trigger) begin
            hit = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ticks(2);
      rst_n = 1'b1;
      ticks(2);
   endtask

   initial begin
      logic hit;
      int   extra;
      int   exp_seq [4];
      int   g;

      rst_n   = 1'b0;
      req     = '0;
      enable  = '1;
      gen_en  = 1'b1;
      gen_len = 15;
      for (int k = 0; k < N; k++) begin
         dly[k] = CW'(100 + k);
         wid[k] = CW'(20 + k);
      end
      dly[0] = 10;
      wid[0] = 5;
      ticks(2);
      chk("rst_trig", 64'(gen_trigger), 0);
      chk("rst_active", 64'(active), 0);
      chk("rst_pending", 64'(pending), 0);
      chk("rst_drop", 64'(drop_cnt), 0);
      chk("rst_timeout", 64'(timeout), 0);
      chk("rst_delay", 64'(gen_delay), 0);
      rst_n = 1'b1;
      ticks(2);

      // single request on 0: pending at t+3, trigger at t+5
      req = 4'b0001;
      ticks(3);
      chk("t1_pend_t2", 64'(pending), 0);
      tick();
      chk("t1_pend_t3", 64'(pending), 64'h1);
      tick();
      chk("t1_trig_t4", 64'(gen_trigger), 0);
      chk("t1_pend_t4", 64'(pending), 0);
      tick();
      chk("t1_trig_t5", 64'(gen_trigger), 1);
      chk("t1_grant", 64'(grant_id), 0);
      chk("t1_delay", 64'(gen_delay), 10);
      chk("t1_width", 64'(gen_width), 5);
      chk("t1_active", 64'(active), 1);
      extra = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (gen_trigger) extra++;
      end
      chk("t1_single_trig", 64'(extra), 0);
      tick();
      chk("t1_active_t22", 64'(active), 1);
      tick();
      chk("t1_active_t23", 64'(active), 0);

      // simultaneous requests on all four, pointer 0
      req = '0;
      gen_len = 3;
      do_reset();
      req = 4'b1111;
      ticks(4);
      chk("t2_pend_all", 64'(pending), 64'hf);
      tick();
      chk("t2_pend_after0", 64'(pending), 64'he);
      tick();
      chk("t2_trig0", 64'(gen_trigger), 1);
      chk("t2_grant0", 64'(grant_id), 0);
      for (int k = 1; k < 4; k++) begin
         wait_trig(40, hit);
         chk("t2_hit", 64'(hit), 1);
         chk("t2_grant", 64'(grant_id), 64'(k));
         chk("t2_pend", 64'(pending), 64'((4'hf << (k + 1)) & 4'hf));
      end
      chk("t2_delay3", 64'(gen_delay), 103);
      chk("t2_drop", 64'(drop_cnt), 0);

      // fairness: the just-served requester retriggers every pulse
      req = '0;
      gen_len = 15;
      do_reset();
      req = 4'b0110;
      exp_seq = '{1, 2, 1, 2};
      for (int i = 0; i < 4; i++) begin
         wait_trig(60, hit);
         chk("t3_hit", 64'(hit), 1);
         chk("t3_grant", 64'(grant_id), 64'(exp_seq[i]));
         g = int'(grant_id);
         req[g] = 1'b0;
         ticks(3);
         req[g] = 1'b1;
      end
      chk("t3_drop", 64'(drop_cnt), 0);

      // drops: three edges on 2 during one long pulse
      req = '0;
      gen_len = 50;
      do_reset();
      req = 4'b0001;
      wait_trig(20, hit);
      chk("t4_hit0", 64'(hit), 1);
      chk("t4_grant0", 64'(grant_id), 0);
      for (int i = 0; i < 3; i++) begin
         req[2] = 1'b1;
         ticks(3);
         req[2] = 1'b0;
         ticks(3);
      end
      ticks(5);
      chk("t4_drop", 64'(drop_cnt), 2);
      chk("t4_pend", 64'(pending), 64'h4);
      wait_trig(80, hit);
      chk("t4_hit2", 64'(hit), 1);
      chk("t4_grant2", 64'(grant_id), 2);
      wait_trig(80, hit);
      chk("t4_no_more", 64'(hit), 0);

      // timeout: generator never acknowledges
      req = '0;
      gen_en = 1'b0;
      do_reset();
      dly[3] = 3;
      wid[3] = 7;
      req = 4'b1000;
      ticks(5);
      chk("t5_trig_t4", 64'(gen_trigger), 0);
      tick();
      chk("t5_trig_t5", 64'(gen_trigger), 1);
      chk("t5_grant", 64'(grant_id), 3);
      chk("t5_width", 64'(gen_width), 7);
      ticks(15);
      chk("t5_to_t20", 64'(timeout), 0);
      chk("t5_act_t20", 64'(active), 1);
      tick();
      chk("t5_to_t21", 64'(timeout), 1);
      chk("t5_act_t21", 64'(active), 0);

      // disabled requester ignores its edge
      enable = 4'b1011;
      req = 4'b1100;
      ticks(6);
      chk("t5_dis_pend", 64'(pending), 0);

      // zero width: pending cleared, no trigger
      enable = '1;
      wid[0] = 0;
      req = 4'b1101;
      ticks(4);
      chk("t5_zw_pend", 64'(pending), 64'h1);
      tick();
      chk("t5_zw_clr", 64'(pending), 0);
      wait_trig(12, hit);
      chk("t5_zw_notrig", 64'(hit), 0);
      chk("t5_to_sticky", 64'(timeout), 1);

      // async reset in the middle of a running pulse
      req = '0;
      gen_en = 1'b1;
      gen_len = 30;
      wid[0] = 5;
      dly[1] = 4;
      wid[1] = 9;
      do_reset();
      req = 4'b0010;
      wait_trig(20, hit);
      chk("t6_hit", 64'(hit), 1);
      ticks(6);
      chk("t6_active_run", 64'(active), 1);
      #2;
      rst_n = 1'b0;
      req = '0;
      #1;
      chk("t6_rst_active", 64'(active), 0);
      chk("t6_rst_trig", 64'(gen_trigger), 0);
      chk("t6_rst_grant", 64'(grant_id), 0);
      chk("t6_rst_delay", 64'(gen_delay), 0);
      chk("t6_rst_width", 64'(gen_width), 0);
      chk("t6_rst_timeout", 64'(timeout), 0);
      #2;
      rst_n = 1'b1;
      ticks(3);
      req = 4'b0010;
      ticks(5);
      chk("t6_trig_t4", 64'(gen_trigger), 0);
      tick();
      chk("t6_trig_t5", 64'(gen_trigger), 1);
      chk("t6_grant", 64'(grant_id), 1);
      chk("t6_delay", 64'(gen_delay), 4);
      chk("t6_width", 64'(gen_width), 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
